mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the ALU: consumes the registered ALU result as an effective address for LW/SW, or passes it through as writeback data for all other instructions.
- Drives a single-port data-memory request/acknowledge interface.
- Stalls the upstream pipeline while an access is outstanding.
- Produces one registered writeback beat per accepted instruction that writes a register.

Parameters:
DMEM_AW, 12, word-address width; dmem_addr = alu_rslt[DMEM_AW+1:2]
TIMEOUT, 255, max cycles waiting for dmem_ack before aborting (1..2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  instruction presented this cycle (ignored while stall=1)
opcode  in  6  instruction opcode (codes from the shared instruction definitions)
alu_rslt  in  32  ALU result: address for loads and stores, data otherwise
st_data  in  32  store data (rt register value)
rd_in  in  5  destination register
we_in  in  1  instruction writes a register
stall  out  1  upstream must hold; in_valid is not sampled
dmem_req  out  1  access request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  DMEM_AW  word address
dmem_wdata  out  32  write data
dmem_be  out  4  byte enables (4'hF unless MEM_BYTE_EN)
dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle
dmem_rdata  in  32  read data
wb_valid  out  1  writeback beat, one-cycle pulse
wb_rd  out  5  writeback register
wb_data  out  32  writeback data
err  out  1  one-cycle pulse on misaligned access or timeout

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0. Reset asserted mid-access drops dmem_req immediately (asynchronous) and discards the access.
- States:
  - IDLE: stall=0. On in_valid:
    - Non-memory opcode: next cycle wb_valid=we_in, wb_data=alu_rslt, wb_rd=rd_in. Latency 1.
    - LW/SW with alu_rslt[1:0]==0: next cycle dmem_req=1, address, we and wdata registered. Go to BUSY.
    - LW/SW with alu_rslt[1:0]!=0: next cycle err=1, no request, no writeback. Stay in IDLE.
  - BUSY: stall=1; dmem_req, addr, we and wdata held stable; counter increments each cycle.
    - dmem_ack=1: dmem_req=0 next cycle, return to IDLE, stall deasserts that same next cycle.
      - Load: wb_valid=we_in pulse with wb_data=dmem_rdata.
      - Store: no writeback.
    - counter==TIMEOUT with no ack: dmem_req=0, err pulse, no writeback, return to IDLE.
- The stall=0 cycle after returning to IDLE may accept a new instruction. Back-to-back memory ops therefore cost at least 2 cycles each.
- dmem_ack while in IDLE is ignored.
- wb_valid and err are never asserted together.
- Register 0 writes pass through; suppression is the register file's job.

Optional Feature:
MEM_BYTE_EN
- Defined: LB, LBU and SB are also accepted, with no alignment check for byte ops.
  - SB: dmem_be = one-hot of addr[1:0]; st_data[7:0] replicated on all four lanes.
  - LB/LBU: select byte addr[1:0] of dmem_rdata, then sign- or zero-extend.
- Undefined: these opcodes are treated as non-memory (pass-through), and dmem_be is constant 4'hF.

Decomposition:
- Opcode codes come from the shared instruction definitions.
- State encoding (IDLE, BUSY) and byte-lane constants go in a shared mem-stage package.
- Natural sub-module: mem_align, a combinational byte-lane insert/extract. Instantiated only when MEM_BYTE_EN is defined.

Test Plan:
- ADDU passthrough: in_valid, alu_rslt=32'h1234, rd_in=5, we_in=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=32'h1234, stall=0, dmem_req=0.
- LW at 0x10, ack 3 cycles after req with rdata=32'hDEADBEEF:
  - dmem_addr=4, stall=1 for 4 cycles.
  - Then wb_data=32'hDEADBEEF with wb_valid pulse.
- SW at 0x8, st_data=32'hCAFE -> dmem_we=1, dmem_wdata=32'hCAFE, dmem_be=4'hF, no wb_valid after ack.
- LW at 0x6 (misaligned) -> err pulse next cycle, dmem_req never asserted, no writeback.
- LW with no ack, TIMEOUT=4 -> dmem_req high 4 cycles, then err pulse, stall released, state IDLE.
- rst low during BUSY -> dmem_req=0 immediately; after release, a pass-through instruction completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
//------------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory pipeline stage:
//   - opcode codes of the instructions the stage recognises
//   - sequencer state encoding (IDLE / BUSY)
//   - byte-lane constants and a lane-select helper
// Build option: MEM_BYTE_EN (byte loads/stores), see mem_stage.sv.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package mem_stage_pkg;

   // Instruction opcodes (bits [31:26] of the instruction word)
   localparam logic [5:0] OP_SPECIAL = 6'h00;   // R-type (ADDU, SUBU, ...)
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SW      = 6'h2B;

   // Access sequencer states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Byte-lane enables
   localparam logic [3:0] BE_ALL = 4'hF;

   // One-hot byte enable for the lane addressed by the low address bits
   function automatic logic [3:0] lane_onehot(input logic [1:0] off);
      logic [3:0] be;
      case (off)
         2'd0:    be = 4'b0001;
         2'd1:    be = 4'b0010;
         2'd2:    be = 4'b0100;
         2'd3:    be = 4'b1000;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_align.sv
//------------------------------------------------------------------------------
// mem_align
// Combinational byte-lane insert (stores) and extract (loads).
// Only elaborated in the MEM_BYTE_EN build, where mem_stage instantiates it.
// Ports:
//   wr_off_i   in   2  byte offset of the store address
//   st_byte_i  in   8  store byte (rt[7:0])
//   rd_off_i   in   2  byte offset of the outstanding load
//   sign_ext_i in   1  1 = LB (sign-extend), 0 = LBU (zero-extend)
//   rdata_i    in  32  raw memory read data
//   wdata_o    out 32  store byte replicated on all four lanes
//   be_o       out  4  one-hot byte enable for the store lane
//   rdata_o    out 32  selected and extended load byte
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`ifdef MEM_BYTE_EN
module mem_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  wr_off_i,
   input  logic [7:0]  st_byte_i,
   input  logic [1:0]  rd_off_i,
   input  logic        sign_ext_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] rdata_o
);

   logic [7:0] byte_s;

   // Store path: same byte on every lane, memory writes only the enabled one
   always_comb begin
      wdata_o = {4{st_byte_i}};
      be_o    = lane_onehot(wr_off_i);
   end

   // Load path: pick the addressed byte and extend to a full word
   always_comb begin
      case (rd_off_i)
         2'd0:    byte_s = rdata_i[7:0];
         2'd1:    byte_s = rdata_i[15:8];
         2'd2:    byte_s = rdata_i[23:16];
         2'd3:    byte_s = rdata_i[31:24];
         default: byte_s = 8'h00;
      endcase
      if (sign_ext_i) begin
         rdata_o = {{24{byte_s[7]}}, byte_s};
      end else begin
         rdata_o = {24'h000000, byte_s};
      end
   end

endmodule
`endif

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// mem_stage
// Pipeline stage after the ALU. LW/SW use alu_rslt as the effective address
// and run a request/acknowledge access on the data memory while stalling the
// upstream pipeline; all other instructions pass alu_rslt through as
// writeback data with one cycle of latency.
// Build option: MEM_BYTE_EN adds LB/LBU/SB (via mem_align); without it those
// opcodes are plain pass-through and dmem_be is tied to 4'hF.
// Parameters: DMEM_AW word-address width, TIMEOUT ack wait limit (cycles),
//             TO_W timeout counter width.
// Ports:
//   clk, rst             clock / asynchronous active-low reset
//   in_valid, opcode, alu_rslt, st_data, rd_in, we_in   instruction in
//   stall                upstream hold (access outstanding)
//   dmem_req/we/addr/wdata/be, dmem_ack/rdata           data memory port
//   wb_valid, wb_rd, wb_data                            writeback beat
//   err                  pulse on misaligned access or ack timeout
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DMEM_AW = 12,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [5:0]         opcode,
   input  logic [31:0]        alu_rslt,
   input  logic [31:0]        st_data,
   input  logic [4:0]         rd_in,
   input  logic               we_in,
   output logic               stall,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [31:0]        dmem_wdata,
   output logic [3:0]         dmem_be,
   input  logic               dmem_ack,
   input  logic [31:0]        dmem_rdata,
   output logic               wb_valid,
   output logic [4:0]         wb_rd,
   output logic [31:0]        wb_data,
   output logic               err
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0] CNT_ZERO = {TO_W{1'b0}};
   localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

   state_e              state_q,    state_d;
   logic                stall_q,    stall_d;
   logic                req_q,      req_d;
   logic                we_q,       we_d;
   logic [DMEM_AW-1:0]  addr_q,     addr_d;
   logic [31:0]         wdata_q,    wdata_d;
   logic [TO_W-1:0]     cnt_q,      cnt_d;
   logic [4:0]          rd_lat_q,   rd_lat_d;
   logic                wen_lat_q,  wen_lat_d;
   logic                wb_valid_q, wb_valid_d;
   logic [4:0]          wb_rd_q,    wb_rd_d;
   logic [31:0]         wb_data_q,  wb_data_d;
   logic                err_q,      err_d;

   logic                is_word_s;
   logic                is_byte_s;
   logic                is_store_s;
   logic                is_mem_s;
   logic                misalign_s;
   logic [31:0]         st_lanes_s;
   logic [31:0]         ld_data_s;

   // Classify the presented opcode; byte ops are exempt from the alignment check
   always_comb begin
      is_word_s  = (opcode == OP_LW) || (opcode == OP_SW);
`ifdef MEM_BYTE_EN
      is_byte_s  = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
      is_store_s = (opcode == OP_SW) || (opcode == OP_SB);
`else
      is_byte_s  = 1'b0;
      is_store_s = (opcode == OP_SW);
`endif
      is_mem_s   = is_word_s || is_byte_s;
      misalign_s = is_word_s && (alu_rslt[1:0] != 2'b00);
   end

`ifdef MEM_BYTE_EN
   logic        start_s;
   logic        byte_q;
   logic        sext_q;
   logic [1:0]  off_q;
   logic [3:0]  be_q;
   logic [31:0] byte_wdata_s;
   logic [31:0] byte_rdata_s;
   logic [3:0]  byte_be_s;
   logic [3:0]  st_be_s;

   assign start_s = (state_q == ST_IDLE) && in_valid && is_mem_s && !misalign_s;

   mem_align u_align (
      .wr_off_i   (alu_rslt[1:0]),
      .st_byte_i  (st_data[7:0]),
      .rd_off_i   (off_q),
      .sign_ext_i (sext_q),
      .rdata_i    (dmem_rdata),
      .wdata_o    (byte_wdata_s),
      .be_o       (byte_be_s),
      .rdata_o    (byte_rdata_s)
   );

   // Select word or byte lanes for the store data and the load result
   always_comb begin
      if (is_byte_s) begin
         st_lanes_s = byte_wdata_s;
         st_be_s    = byte_be_s;
      end else begin
         st_lanes_s = st_data;
         st_be_s    = BE_ALL;
      end
      if (byte_q) begin
         ld_data_s = byte_rdata_s;
      end else begin
         ld_data_s = dmem_rdata;
      end
   end

   // Byte-lane controls captured when an access is launched
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_q <= 1'b0;
         sext_q <= 1'b0;
         off_q  <= 2'b00;
         be_q   <= 4'h0;
      end else if (start_s) begin
         byte_q <= is_byte_s;
         sext_q <= (opcode == OP_LB);
         off_q  <= alu_rslt[1:0];
         be_q   <= st_be_s;
      end
   end

   assign dmem_be = be_q;
`else
   // Word-only build: data passes straight through
   always_comb begin
      st_lanes_s = st_data;
      ld_data_s  = dmem_rdata;
   end

   assign dmem_be = BE_ALL;
`endif

   // Access sequencer: accept, launch, wait for ack or timeout, write back
   always_comb begin
      state_d    = state_q;
      stall_d    = stall_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rd_lat_d   = rd_lat_q;
      wen_lat_d  = wen_lat_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (!is_mem_s) begin
                  wb_valid_d = we_in;
                  wb_rd_d    = rd_in;
                  wb_data_d  = alu_rslt;
               end else if (misalign_s) begin
                  err_d = 1'b1;
               end else begin
                  state_d   = ST_BUSY;
                  stall_d   = 1'b1;
                  req_d     = 1'b1;
                  we_d      = is_store_s;
                  addr_d    = alu_rslt[DMEM_AW+1:2];
                  wdata_d   = st_lanes_s;
                  // counter holds the number of BUSY cycles including the current one
                  cnt_d     = CNT_ONE;
                  rd_lat_d  = rd_in;
                  wen_lat_d = we_in && !is_store_s;
               end
            end else begin
               cnt_d = CNT_ZERO;
            end
         end
         ST_BUSY: begin
            if (dmem_ack) begin
               state_d    = ST_IDLE;
               stall_d    = 1'b0;
               req_d      = 1'b0;
               cnt_d      = CNT_ZERO;
               // stores latch wen_lat=0, so only loads that write a register pulse here
               wb_valid_d = wen_lat_q;
               if (wen_lat_q) begin
                  wb_rd_d   = rd_lat_q;
                  wb_data_d = ld_data_s;
               end else begin
                  wb_rd_d   = wb_rd_q;
               end
            end else if (cnt_q == TO_LIMIT) begin
               state_d = ST_IDLE;
               stall_d = 1'b0;
               req_d   = 1'b0;
               cnt_d   = CNT_ZERO;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            stall_d = 1'b0;
            req_d   = 1'b0;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         stall_q    <= 1'b0;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= {DMEM_AW{1'b0}};
         wdata_q    <= 32'h0000_0000;
         cnt_q      <= CNT_ZERO;
         rd_lat_q   <= 5'd0;
         wen_lat_q  <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'h0000_0000;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         stall_q    <= stall_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rd_lat_q   <= rd_lat_d;
         wen_lat_q  <= wen_lat_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         err_q      <= err_d;
      end
   end

   assign stall      = stall_q;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign err        = err_q;

endmodule

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage (default build, TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int DMEM_AW = 12;
   localparam int TIMEOUT = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic [5:0]         opcode;
   logic [31:0]        alu_rslt;
   logic [31:0]        st_data;
   logic [4:0]         rd_in;
   logic               we_in;
   logic               stall;
   logic               dmem_req;
   logic               dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [31:0]        dmem_wdata;
   logic [3:0]         dmem_be;
   logic               dmem_ack;
   logic [31:0]        dmem_rdata;
   logic               wb_valid;
   logic [4:0]         wb_rd;
   logic [31:0]        wb_data;
   logic               err;

   int checks = 0;
   int errors = 0;

   mem_stage #(.DMEM_AW(DMEM_AW), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .opcode     (opcode),
      .alu_rslt   (alu_rslt),
      .st_data    (st_data),
      .rd_in      (rd_in),
      .we_in      (we_in),
      .stall      (stall),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_be    (dmem_be),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic present(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] rd, input logic w);
      in_valid = 1'b1;
      opcode   = op;
      alu_rslt = a;
      st_data  = sd;
      rd_in    = rd;
      we_in    = w;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b expected 0", dmem_req); end
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", dmem_we); end
      checks++; if (dmem_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", dmem_addr); end
      checks++; if (dmem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", dmem_wdata); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0b expected 0", wb_valid); end
      checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d expected 0", wb_rd); end
      checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_passthrough();
      present(OP_SPECIAL, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
      @(negedge clk);
      present(OP_SPECIAL, 32'hA5A5_0001, 32'h0, 5'd6, 1'b0);
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL pass_wb_valid: got %0b expected 1", wb_valid); end
      checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL pass_wb_rd: got %0d expected 5", wb_rd); end
      checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL pass_wb_data: got %h expected 00001234", wb_data); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pass_stall: got %0b expected 0", stall); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL pass_req: got %0b expected 0", dmem_req); end
      @(negedge clk);
      in_valid = 1'b0;
      // we_in=0 instruction: no writeback beat
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL pass_no_we: got %0b expected 0", wb_valid); end
   endtask

   task automatic test_lw();
      present(OP_LW, 32'h0000_0010, 32'h0, 5'd7, 1'b1);
      @(negedge clk);
      // an instruction presented while stalled must be ignored
      present(OP_SPECIAL, 32'h0000_0999, 32'h0, 5'd1, 1'b1);
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL lw_req: got %0b expected 1", dmem_req); end
      checks++; if (dmem_addr !== 12'h004) begin errors++; $display("FAIL lw_addr: got %h expected 004", dmem_addr); end
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL lw_we: got %0b expected 0", dmem_we); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall_c1: got %0b expected 1", stall); end
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall_c%0d: got %0b expected 1", k, stall); end
         checks++; if (dmem_req !== 1'b1 || dmem_addr !== 12'h004) begin errors++; $display("FAIL lw_hold_c%0d: got req %0b addr %h expected req 1 addr 004", k, dmem_req, dmem_addr); end
         checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lw_early_wb_c%0d: got %0b expected 0", k, wb_valid); end
      end
      in_valid   = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lw_wb_valid: got %0b expected 1", wb_valid); end
      checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wb_data: got %h expected deadbeef", wb_data); end
      checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL lw_wb_rd: got %0d expected 7", wb_rd); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_stall_release: got %0b expected 0", stall); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL lw_req_drop: got %0b expected 0", dmem_req); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_err: got %0b expected 0", err); end
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lw_wb_pulse: got %0b expected 0", wb_valid); end
   endtask

   task automatic test_sw();
      present(OP_SW, 32'h0000_0008, 32'h0000_CAFE, 5'd9, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL sw_req: got %0b expected 1", dmem_req); end
      checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %0b expected 1", dmem_we); end
      checks++; if (dmem_wdata !== 32'h0000_CAFE) begin errors++; $display("FAIL sw_wdata: got %h expected 0000cafe", dmem_wdata); end
      checks++; if (dmem_be !== 4'hF) begin errors++; $display("FAIL sw_be: got %h expected f", dmem_be); end
      checks++; if (dmem_addr !== 12'h002) begin errors++; $display("FAIL sw_addr: got %h expected 002", dmem_addr); end
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL sw_req_drop: got %0b expected 0", dmem_req); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sw_no_wb: got %0b expected 0", wb_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sw_stall: got %0b expected 0", stall); end
   endtask

   task automatic test_misaligned();
      present(OP_LW, 32'h0000_0006, 32'h0, 5'd4, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %0b expected 1", err); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %0b expected 0", dmem_req); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mis_wb: got %0b expected 0", wb_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %0b expected 0", stall); end
      @(negedge clk);
      checks++; if (err !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL mis_after: got err %0b req %0b expected 0 0", err, dmem_req); end
   endtask

   task automatic test_timeout();
      int n;
      present(OP_LW, 32'h0000_0020, 32'h0, 5'd8, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (dmem_req === 1'b1 && n < 10) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL to_req_cycles: got %0d expected %0d", n, TIMEOUT); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %0b expected 1", err); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_stall: got %0b expected 0", stall); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL to_wb: got %0b expected 0", wb_valid); end
      // back in IDLE: a pass-through is accepted right away
      present(OP_SPECIAL, 32'h0000_0777, 32'h0, 5'd11, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0777) begin errors++; $display("FAIL to_idle_pass: got valid %0b data %h expected 1 00000777", wb_valid, wb_data); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %0b expected 0", err); end
   endtask

   task automatic test_ack_idle();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1357_9BDF;
      @(negedge clk);
      dmem_ack   = 1'b0;
      checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL ack_idle: got wb %0b req %0b stall %0b err %0b expected 0 0 0 0", wb_valid, dmem_req, stall, err); end
   endtask

   task automatic test_back_to_back();
      present(OP_LW, 32'h0000_0100, 32'h0, 5'd9, 1'b1);
      @(negedge clk);
      in_valid   = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1111_2222;
      @(negedge clk);
      dmem_ack   = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h1111_2222 || wb_rd !== 5'd9) begin errors++; $display("FAIL b2b_load_wb: got %0b %h %0d expected 1 11112222 9", wb_valid, wb_data, wb_rd); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0b expected 0", stall); end
      present(OP_SW, 32'h0000_0104, 32'h0000_0033, 5'd0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 12'h041) begin errors++; $display("FAIL b2b_store_req: got req %0b we %0b addr %h expected 1 1 041", dmem_req, dmem_we, dmem_addr); end
      checks++; if (dmem_wdata !== 32'h0000_0033) begin errors++; $display("FAIL b2b_store_wdata: got %h expected 00000033", dmem_wdata); end
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_store_done: got req %0b wb %0b expected 0 0", dmem_req, wb_valid); end
   endtask

   task automatic test_byte_ops_default();
      logic [5:0]  ops [3];
      logic [31:0] vals [3];
      ops[0] = OP_LB;  vals[0] = 32'h0000_0013;
      ops[1] = OP_LBU; vals[1] = 32'h8000_0021;
      ops[2] = OP_SB;  vals[2] = 32'h0000_0042;
      for (int i = 0; i < 3; i++) begin
         present(ops[i], vals[i], 32'hFFFF_FFFF, 5'(i + 2), 1'b1);
         @(negedge clk);
         in_valid = 1'b0;
         checks++; if (wb_valid !== 1'b1 || wb_data !== vals[i] || wb_rd !== 5'(i + 2)) begin errors++; $display("FAIL byte_pass_%0d: got %0b %h %0d expected 1 %h %0d", i, wb_valid, wb_data, wb_rd, vals[i], i + 2); end
         checks++; if (dmem_req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL byte_noreq_%0d: got req %0b err %0b expected 0 0", i, dmem_req, err); end
      end
   endtask

   task automatic test_reset_busy();
      present(OP_LW, 32'h0000_0040, 32'h0, 5'd12, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstb_req_before: got %0b expected 1", dmem_req); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstb_req_async: got %0b expected 0", dmem_req); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstb_stall_async: got %0b expected 0", stall); end
      @(negedge clk);
      rst = 1'b1;
      present(OP_SPECIAL, 32'h0000_0055, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0000_0055 || wb_rd !== 5'd3) begin errors++; $display("FAIL rstb_pass: got %0b %h %0d expected 1 00000055 3", wb_valid, wb_data, wb_rd); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rstb_req_after: got %0b expected 0", dmem_req); end
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL rstb_discard: got wb %0b req %0b expected 0 0", wb_valid, dmem_req); end
   endtask

   initial begin
      rst        = 1'b0;
      in_valid   = 1'b0;
      opcode     = 6'h00;
      alu_rslt   = 32'h0;
      st_data    = 32'h0;
      rd_in      = 5'd0;
      we_in      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      test_reset();
      test_passthrough();
      test_lw();
      test_sw();
      test_misaligned();
      test_timeout();
      test_ack_idle();
      test_back_to_back();
      test_byte_ops_default();
      test_reset_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
